// File: rtl/dma_pkg.sv
// Shared definitions for the DMA master: bus width defaults, index width
// and the controller state encoding.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 8;
    localparam int unsigned DMA_DATA_W = 32;
    localparam int unsigned LEN_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } dma_state_e;

    // Every state except IDLE belongs to an active copy.
    function automatic logic state_is_busy(input dma_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/dma_idx_ctr.sv
// Word index for the DMA copy: cleared on an accepted start, advanced on
// each granted write, and flags the last word of the copy.
module dma_idx_ctr
    import dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] idx,
    output logic [LEN_W-1:0] idx_nxt,
    output logic             last
);

    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] idx_d;

    // Next index value; clear has priority over increment.
    always_comb begin
        idx_d   = idx_q;
        idx_nxt = idx_q + LEN_W'(1);
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_nxt;
        end
        // len never exceeds 255, so idx+1 never wraps before matching len.
        last = (idx_nxt == len);
    end

    // Index register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/dma_master.sv
// Single-channel DMA master: copies len words from src_addr to dst_addr
// over an arbitrated bus, one read/write pair per word.
module dma_master
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned DATA_W = DMA_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);

    dma_state_e state_q;
    dma_state_e state_d;

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] src_d;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] dst_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    logic              accept;
    logic              idx_inc;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_nxt;
    logic              idx_last;

    dma_idx_ctr u_idx_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .inc     (idx_inc),
        .len     (len_q),
        .idx     (idx),
        .idx_nxt (idx_nxt),
        .last    (idx_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (m_grant) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (m_grant) begin
                    state_d = idx_last ? ST_DONE : ST_RD_ADDR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control outputs decoded from the current state only.
    always_comb begin
        busy    = state_is_busy(state_q);
        done    = (state_q == ST_DONE);
        m_req   = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) || (state_q == ST_WR);
        m_wr    = (state_q == ST_WR);
        accept  = (state_q == ST_IDLE) && start;
        idx_inc = (state_q == ST_WR) && m_grant;
    end

    // Datapath next values: latch the request, and preload the bus address
    // for the state being entered so m_address is a plain register output.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        addr_d = addr_q;
        data_d = data_q;
        if (accept) begin
            src_d = src_addr;
            dst_d = dst_addr;
            len_d = len;
            if (len != '0) begin
                addr_d = src_addr;
            end
        end
        if (state_q == ST_RD_DATA) begin
            data_d = m_din;
            addr_d = dst_q + ADDR_W'(idx);
        end
        if ((state_q == ST_WR) && m_grant && !idx_last) begin
            addr_d = src_q + ADDR_W'(idx_nxt);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign m_address = addr_q;
    assign m_dout    = data_q;

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: table of copy scenarios checked
// through a transfer scoreboard, plus reset sequences.
module tb_dma_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        m_req;
    logic        m_wr;
    logic [7:0]  m_address;
    logic [31:0] m_dout;
    logic        m_grant;
    logic [31:0] m_din;

    dma_master #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_address (m_address),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  len;
        logic [31:0] base;
        int          stall_start;
        int          stall_len;
        int          restart_at;
        int          exp_cycles;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [256];
    xfer_t       exp_q [$];
    xfer_t       mon_e;
    bit          rd_seen = 1'b0;
    bit          rd_pend = 1'b0;
    logic [7:0]  rd_pend_addr = '0;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: read data appears in the cycle after a granted read address cycle.
    always @(negedge clk) begin
        rd_pend      = m_req && m_grant && !m_wr;
        rd_pend_addr = m_address;
    end

    always @(posedge clk) begin
        #1;
        m_din = rd_pend ? mem[rd_pend_addr] : 32'hDEAD_BEEF;
    end

    // Monitor: each granted read address phase and each granted write is
    // one transfer, compared in order against the expected queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_seen = 1'b0;
        end else if (m_req && m_grant && (m_wr || !rd_seen)) begin
            rd_seen = !m_wr;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_xfer: got wr=%0d addr 0x%0h expected no transfer", m_wr, m_address);
            end else begin
                mon_e = exp_q.pop_front();
                check("xfer_kind", {31'b0, m_wr}, {31'b0, mon_e.wr});
                check("xfer_addr", {24'b0, m_address}, {24'b0, mon_e.addr});
                if (mon_e.wr) begin
                    check("xfer_wdata", m_dout, mon_e.data);
                end
            end
        end else if (!(m_req && !m_wr)) begin
            rd_seen = 1'b0;
        end
    end

    task automatic load_copy(input logic [7:0] src, input logic [7:0] dst,
                             input logic [7:0] n, input logic [31:0] base);
        logic [7:0] ra;
        logic [7:0] wa;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 32'hBAD0_0000 | a;
        end
        for (int i = 0; i < int'(n); i++) begin
            ra = src + 8'(i);
            wa = dst + 8'(i);
            mem[ra] = base + 32'(i);
            exp_q.push_back('{wr: 1'b0, addr: ra, data: 32'h0});
            exp_q.push_back('{wr: 1'b1, addr: wa, data: base + 32'(i)});
        end
    endtask

    task automatic pulse_start(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] n);
        @(posedge clk);
        #1;
        src_addr = src;
        dst_addr = dst;
        len      = n;
        start    = 1'b1;
        m_grant  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_copy(input vec_t v, input int vi);
        int          k;
        bit          got_done;
        bit          req_seen;
        logic [7:0]  h_addr;
        logic        h_wr;
        logic [31:0] h_dout;
        h_addr = '0;
        h_wr   = 1'b0;
        h_dout = '0;
        load_copy(v.src, v.dst, v.len, v.base);
        pulse_start(v.src, v.dst, v.len);
        k        = 1;
        got_done = 1'b0;
        req_seen = 1'b0;
        m_grant  = !(v.stall_len > 0 && k >= v.stall_start && k < v.stall_start + v.stall_len);
        while (k <= 2000) begin
            @(negedge clk);
            if (m_req) req_seen = 1'b1;
            if (k == 1) check($sformatf("v%0d_busy_after_start", vi), {31'b0, busy}, 32'd1);
            if (v.stall_len > 0 && k == v.stall_start) begin
                h_addr = m_address;
                h_wr   = m_wr;
                h_dout = m_dout;
            end else if (v.stall_len > 0 && k > v.stall_start && k < v.stall_start + v.stall_len) begin
                check($sformatf("v%0d_stall_addr", vi), {24'b0, m_address}, {24'b0, h_addr});
                check($sformatf("v%0d_stall_wr", vi), {31'b0, m_wr}, {31'b0, h_wr});
                check($sformatf("v%0d_stall_dout", vi), m_dout, h_dout);
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            k++;
            m_grant = !(v.stall_len > 0 && k >= v.stall_start && k < v.stall_start + v.stall_len);
            start   = (k == v.restart_at);
            if (start) begin
                src_addr = 8'h55;
                dst_addr = 8'h66;
                len      = 8'd9;
            end
        end
        check($sformatf("v%0d_done_seen", vi), {31'b0, got_done}, 32'd1);
        check($sformatf("v%0d_done_cycle", vi), k, v.exp_cycles);
        check($sformatf("v%0d_req_seen", vi), {31'b0, req_seen}, {31'b0, v.len != 8'd0});
        @(posedge clk);
        #1;
        start   = 1'b0;
        m_grant = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", vi), {31'b0, done}, 32'd0);
        check($sformatf("v%0d_busy_idle", vi), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d_req_idle", vi), {31'b0, m_req}, 32'd0);
        check($sformatf("v%0d_queue_drained", vi), exp_q.size(), 32'd0);
        if (v.len != 8'd0) begin
            check($sformatf("v%0d_idle_addr_hold", vi), {24'b0, m_address}, {24'b0, v.dst + v.len - 8'd1});
            check($sformatf("v%0d_idle_dout_hold", vi), m_dout, v.base + 32'(v.len) - 32'd1);
        end
        exp_q.delete();
    endtask

    initial begin
        bit   saw_done;
        vec_t fresh;

        //            src    dst    len     base           stall  slen  restart cycles
        vecs[0] = '{8'h01, 8'h21, 8'd1,   32'h1234_5678, 0,     0,    0,      4};
        vecs[1] = '{8'h01, 8'h21, 8'd4,   32'h0000_00A0, 0,     0,    5,      13};
        vecs[2] = '{8'h01, 8'h21, 8'd2,   32'h0000_00C0, 3,     3,    0,      10};
        vecs[3] = '{8'hFE, 8'hFF, 8'd3,   32'h5500_0000, 0,     0,    0,      10};
        vecs[4] = '{8'h00, 8'h00, 8'd0,   32'h0000_0000, 0,     0,    0,      1};
        vecs[5] = '{8'h30, 8'h40, 8'd3,   32'h0000_7000, 4,     2,    0,      12};
        vecs[6] = '{8'h80, 8'hC0, 8'd2,   32'h0BAD_F00D, 2,     1,    0,      7};
        vecs[7] = '{8'h10, 8'h90, 8'd255, 32'h0001_0000, 0,     0,    0,      766};

        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        m_grant  = 1'b1;
        m_din    = '0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_req", {31'b0, m_req}, 32'd0);
        check("rst_wr", {31'b0, m_wr}, 32'd0);
        check("rst_addr", {24'b0, m_address}, 32'd0);
        check("rst_dout", m_dout, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_copy(vecs[i], i);
        end

        // Reset during the second RD_DATA of a four-word copy: the
        // first word's read and write, and the second read, have happened.
        load_copy(8'h01, 8'h21, 8'd4, 32'h0000_00B0);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        pulse_start(8'h01, 8'h21, 8'd4);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        check("mid_rd_data_req", {31'b0, m_req}, 32'd1);
        check("mid_rd_data_wr", {31'b0, m_wr}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_req", {31'b0, m_req}, 32'd0);
        check("mid_rst_wr", {31'b0, m_wr}, 32'd0);
        check("mid_rst_addr", {24'b0, m_address}, 32'd0);
        check("mid_rst_dout", m_dout, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy || m_req) saw_done = 1'b1;
        end
        check("mid_rst_no_done_no_activity", {31'b0, saw_done}, 32'd0);
        check("mid_rst_queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();

        fresh = '{8'h01, 8'h21, 8'd4, 32'h0000_00D0, 0, 0, 0, 13};
        run_copy(fresh, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_master.md
DMA_MASTER -- requirements
Module: dma_master

Interface
REQ-001 Parameter ADDR_W, default 8, bus address width.
REQ-002 Parameter DATA_W, default 32, bus data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a copy when idle.
REQ-006 src_addr  input  ADDR_W  first source word address, sampled on accepted start.
REQ-007 dst_addr  input  ADDR_W  first destination word address, sampled on accepted start.
REQ-008 len  input  8  word count, sampled on accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse on copy completion.
REQ-011 m_req  output  1  bus request to arbiter.
REQ-012 m_wr  output  1  1 = write, 0 = read.
REQ-013 m_address  output  ADDR_W  bus address.
REQ-014 m_dout  output  DATA_W  write data.
REQ-015 m_grant  input  1  arbiter grant; a transfer occurs only in a cycle with m_req and m_grant both high.
REQ-016 m_din  input  DATA_W  read data, valid in the cycle after the read address cycle.

Function
REQ-017 States IDLE, RD_ADDR, RD_DATA, WR, DONE; encoding from the shared package.
REQ-018 IDLE: start=1 -> latch src/dst/len, clear word index; len=0 -> DONE, else RD_ADDR; start is ignored in every non-IDLE state.
REQ-019 RD_ADDR: m_req=1, m_wr=0, m_address=src+idx; remain while m_grant=0; m_grant=1 -> RD_DATA.
REQ-020 RD_DATA: m_req held at 1, m_wr=0; capture m_din into the data register at the clock edge; then WR unconditionally, regardless of m_grant.
REQ-021 WR: m_req=1, m_wr=1, m_address=dst+idx, m_dout=captured word; remain while m_grant=0; m_grant=1 -> idx+1, then DONE if idx+1==len, else RD_ADDR.
REQ-022 DONE: done=1 for exactly one cycle, m_req=0; next state IDLE.
REQ-023 Address arithmetic is modulo 2^ADDR_W; src+idx and dst+idx wrap 0xFF -> 0x00.
REQ-024 len=255 copies 255 words; the index is 8 bits and does not overflow.
REQ-025 Latency per word with continuous grant: 3 cycles (RD_ADDR, RD_DATA, WR); a copy of N words = 3N+1 cycles from the start edge to the done pulse.
REQ-026 Grant loss in RD_ADDR or WR stalls the state machine with address, m_wr and m_dout held stable; no word is skipped or repeated.
REQ-027 In IDLE, m_req=0, m_wr=0, and m_address/m_dout hold their last values.
REQ-028 busy=1 in RD_ADDR, RD_DATA, WR and DONE; busy=0 in IDLE.

Reset
REQ-029 reset_n=0 forces immediately: state IDLE; busy, done, m_req and m_wr 0; m_address 0; m_dout 0; index and latched registers 0.
REQ-030 Reset asserted mid-copy aborts the copy without a done pulse; after release the block idles until the next start.

Structure
REQ-031 Package dma_pkg holds the state enum, ADDR_W/DATA_W defaults and LEN_W=8.
REQ-032 The single sub-module dma_idx_ctr (clear, increment, compare to len, last flag) holds the word index.
REQ-033 All outputs are registered or decoded from state only; there is no combinational path from m_din to any output.

Verification
REQ-034 Single word: src=0x01, dst=0x21, len=1, grant tied 1, slave returns 0x12345678 -> read @0x01, write @0x21 of 0x12345678, done on cycle 4 after start.
REQ-035 Burst: src=0x01, dst=0x21, len=4, data 0xA0..0xA3 -> four read/write pairs at 0x01..0x04 -> 0x21..0x24, in order, done after 13 cycles.
REQ-036 Grant stall: len=2, grant dropped 3 cycles during the first WR -> m_address=0x21, m_wr=1 and m_dout held; no extra write; done delayed by 3 cycles.
REQ-037 Wrap: src=0xFE, dst=0xFF, len=3 -> reads 0xFE, 0xFF, 0x00; writes 0xFF, 0x00, 0x01.
REQ-038 len=0 -> no m_req assertion; done pulses the cycle after start; start while busy is ignored.
REQ-039 Reset during the second RD_DATA of len=4 -> all outputs 0 immediately, no done pulse; a fresh start afterwards completes normally.
